// File: rtl/calc_display_scan.sv
// calc_display_scan
// Display controller for the calculator. It picks the digit source from the
// calculator state and registers one 5-bit code per digit, with optional
// leading-zero blanking and a blink of the operand being entered. It then
// time-multiplexes those codes onto a single shared code bus.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   state      00 WAIT, 01 LOAD_FIRST, 10 LOAD_SECOND, 11 CALCULATE
//   num1/num2  operands (NUM_W bits)
//   ans        ALU result (ANS_W bits)
//   blank_lz   1 = blank zero digits above the most significant nonzero one
//   digit_code {off, hex[3:0]} of the scanned digit, 5'h10 = OFF
//   digit_sel  one-hot active-low select of the scanned digit
//   scan_idx   index of the scanned digit
//   frame_tick one-cycle pulse when scan_idx wraps to 0
module calc_display_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int NUM_W        = 8,
  parameter int ANS_W        = 10,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            state,
  input  logic [NUM_W-1:0]      num1,
  input  logic [NUM_W-1:0]      num2,
  input  logic [ANS_W-1:0]      ans,
  input  logic                  blank_lz,
  output logic [4:0]            digit_code,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [IDX_W-1:0]      scan_idx,
  output logic                  frame_tick
);

  localparam int PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int NUM_NIB = (NUM_W + 3) / 4;
  localparam int ANS_NIB = (ANS_W + 3) / 4;
  localparam logic [4:0] CODE_OFF = 5'h10;

  typedef enum logic [1:0] {
    ST_WAIT        = 2'b00,
    ST_LOAD_FIRST  = 2'b01,
    ST_LOAD_SECOND = 2'b10,
    ST_CALCULATE   = 2'b11
  } calc_state_t;

  logic [PRE_W-1:0]      prescaler;
  logic [FRM_W-1:0]      frame_cnt;
  logic                  blink_phase;
  logic [1:0]            state_q;
  logic [4:0]            digitreg   [NUM_DIGITS];
  logic [4:0]            next_digit [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] src_ext;
  int                    src_nibs;
  logic                  blink_off;
  logic                  leading;
  logic [3:0]            nib;
  logic                  state_changed;
  logic                  pre_tc;
  logic                  frame_wrap;

  assign state_changed = (state != state_q);
  assign pre_tc        = (prescaler == PRE_W'(REFRESH_DIV - 1));
  assign frame_wrap    = pre_tc && (scan_idx == IDX_W'(NUM_DIGITS - 1));

  // Source selection, blanking and blink gating for the next digit codes.
  // A state change counts as "visible" in the same cycle it is seen, so a
  // freshly entered operand never flashes dark for one cycle.
  always_comb begin
    src_ext   = '0;
    src_nibs  = 0;
    blink_off = 1'b0;
    leading   = 1'b1;
    nib       = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) next_digit[i] = CODE_OFF;
    case (calc_state_t'(state))
      ST_LOAD_FIRST: begin
        src_ext[NUM_W-1:0] = num1;
        src_nibs           = NUM_NIB;
        blink_off          = ~(blink_phase | state_changed);
      end
      ST_LOAD_SECOND: begin
        src_ext[NUM_W-1:0] = num2;
        src_nibs           = NUM_NIB;
        blink_off          = ~(blink_phase | state_changed);
      end
      ST_CALCULATE: begin
        src_ext[ANS_W-1:0] = ans;
        src_nibs           = ANS_NIB;
      end
      default: begin
        src_nibs = 0;
      end
    endcase
    // Walk from the top digit down so "leading" stays set until the first
    // nonzero nibble of the source is passed.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = src_ext[4*i +: 4];
      if (i >= src_nibs || blink_off) begin
        next_digit[i] = CODE_OFF;
      end else if (blank_lz && leading && (nib == 4'h0) && (i != 0)) begin
        next_digit[i] = CODE_OFF;
      end else begin
        next_digit[i] = {1'b0, nib};
      end
      if (i < src_nibs && nib != 4'h0) leading = 1'b0;
    end
  end

  // Prescaler and scan index; the wrap of the index raises frame_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      scan_idx   <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (pre_tc) begin
        prescaler <= '0;
        if (frame_wrap) begin
          scan_idx   <= '0;
          frame_tick <= 1'b1;
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Blink phase: a state change beats a simultaneous blink toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      state_q <= state;
      if (state_changed) begin
        frame_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (frame_wrap) begin
        if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Digit registers reload every cycle. The outputs are both taken from the
  // same scan_idx value, so select and code always move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digitreg[i] <= CODE_OFF;
      digit_code <= CODE_OFF;
      digit_sel  <= '1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) digitreg[i] <= next_digit[i];
      digit_code <= digitreg[scan_idx];
      digit_sel  <= ~(NUM_DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: doc/calc_display_scan.md
# calc_display_scan

Parametrised display controller for the calculator. It selects the digit source from the calculator state (blank, operand 1, operand 2 or result). It registers per-digit codes with optional leading-zero blanking, and blinks the operand being entered. It time-multiplexes the digits onto one shared code bus with an active-low digit select for the seven-segment driver. It sits between the calculator state machine / ALU and the segment decoder.

## Interface

Parameters:
- NUM_DIGITS, 4: digits driven; must be ≥ ceil(ANS_W/4) and ≥ ceil(NUM_W/4).
- NUM_W, 8: operand width.
- ANS_W, 10: result width.
- REFRESH_DIV, 100000: clk cycles each digit stays selected; ≥ 2.
- BLINK_FRAMES, 64: full scan frames per blink half-period; ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  **one clock; reset is synchronous and active-high**.
- state  in  2  00 WAIT, 01 LOAD_FIRST, 10 LOAD_SECOND, 11 CALCULATE.
- num1  in  NUM_W  first operand.
- num2  in  NUM_W  second operand.
- ans  in  ANS_W  result.
- blank_lz  in  1  1 = blank leading zero digits.
- digit_code  out  5  {off, hex[3:0]}; 5'h10 = OFF.
- digit_sel  out  NUM_DIGITS  one-hot active-low select of the scanned digit.
- scan_idx  out  clog2(NUM_DIGITS)  index of the scanned digit.
- frame_tick  out  1  one-cycle pulse when scan_idx wraps to 0.

## Operation

- **Source per state:**
  - WAIT: all digits OFF.
  - LOAD_FIRST: num1 nibbles.
  - LOAD_SECOND: num2 nibbles.
  - CALCULATE: ans nibbles, with the top nibble zero-extended.
  - Digit positions beyond the source's nibble count are OFF.
- **Digit registers:** a NUM_DIGITS × 5 array, reloaded every clk from the selected source.
- **Leading-zero blanking:** when blank_lz = 1, zero nibbles above the most significant nonzero nibble are OFF. Digit 0 is never blanked by this rule, so value 0 shows "0".
- **Blink:** in LOAD_FIRST and LOAD_SECOND, all operand digits are OFF while blink_phase = 0. CALCULATE never blinks.
- **Blink phase counter:** blink_phase toggles after every BLINK_FRAMES frame_ticks.
- **State change:** any change of `state` forces blink_phase = 1 and clears the frame counter, so a newly entered operand is visible at once.
- **Scan:**
  - The prescaler counts 0..REFRESH_DIV-1.
  - At the terminal count the prescaler returns to 0 and scan_idx advances, wrapping NUM_DIGITS-1 → 0.
  - The wrap raises frame_tick for that one cycle.
- **Outputs:** digit_code = digitreg[scan_idx] and digit_sel = ~(1 << scan_idx), both registered.

## Timing

- **Reset values:**
  - digit_code = 5'h10, digit_sel all 1s, scan_idx = 0, frame_tick = 0.
  - Prescaler = 0, frame counter = 0, blink_phase = 1, all digit registers OFF.
- **After reset release:** the first edge drives digit_sel = ~1. Each digit is selected for exactly REFRESH_DIV cycles; a frame lasts NUM_DIGITS × REFRESH_DIV cycles.
- **Input latency:** a change on state/num/ans/blank_lz reaches the digit registers at edge +1. It reaches digit_code at edge +2 if that digit is currently selected.
- **Consistency:** digit_sel and digit_code always change on the same edge and always refer to the same scan_idx.
- **Simultaneous events:** a state change on the same edge as a blink toggle resolves with blink_phase = 1 (state change wins).
- **Reset mid-operation:** reset has priority over every counter and register. The outputs show reset values on the edge where reset is sampled high.
- **No handshake:** inputs are sampled every cycle.

## Test plan

Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.

1. **Reset:** reset high 3 cycles.
   - During reset: digit_code = 10, digit_sel = 1111, frame_tick = 0.
   - After release: digit_sel 1110 → 1101 → 1011 → 0111 every 4 cycles.
   - frame_tick pulses once per 16 cycles.
2. **CALCULATE, no blanking:** ans = 10'h2A5, blank_lz = 0.
   - Scanned codes for digits 0..3 = 05, 0A, 02, 10, repeating every frame.
3. **CALCULATE, blanking:** blank_lz = 1.
   - ans = 10'h005 → 05, 10, 10, 10.
   - ans = 0 → 00, 10, 10, 10.
   - ans = 10'h100 → 00, 00, 01, 10.
4. **LOAD_FIRST blink:** num1 = 8'h3C.
   - Two frames of 0C, 03, 10, 10, then two frames all 10, repeating.
   - Switch to LOAD_SECOND with num2 = 8'h07 during the dark phase: 07, 00 (blank_lz = 0) visible within 2 cycles.
5. **WAIT and mid-scan reset:** state = WAIT with ans = 3FF → all codes 10.
   - Assert reset while scan_idx = 2 → next edge shows digit_sel = 1111, scan_idx = 0, digit_code = 10.
